cpu_scheduler: RTL and testbench

CPU_SCHEDULER -- requirements
Module: cpu_scheduler

---
 rtl/cpu_scheduler.sv | 158 +++++++++++++++
 tb/tb_cpu_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_scheduler.sv
// ---------------------------------------------------------------------------
// cpu_scheduler
//
// Paces a CPU against a reference clock and hands the CPU bus to a DMA
// requester between CPU cycles.
//
// Rate pacing
//   A fractional accumulator runs at the reference rate. The CPU gets a
//   running cycle (hold=1) each time the accumulator reaches cur_fref.
//   The effective rate is min(cur_freq, cur_fref). cur_fref==0 means
//   full speed.
//
// Configuration
//   New rates are written into a shadow register pair. They are applied
//   only on a tick, so the pacing phase restarts cleanly.
//
// DMA arbitration
//   RUN -> DRAIN (CPU finishes its bus cycle) -> DMA (grant) -> RUN.
//   After a burst the CPU is owed at least one running cycle before
//   another burst is allowed.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   cfg_we     in   load cfg_freq/cfg_fref into the shadow registers
//   cfg_freq   in   [7:0] requested CPU rate numerator
//   cfg_fref   in   [7:0] reference rate denominator
//   dma_req    in   DMA requests the bus
//   dma_last   in   final DMA bus cycle (meaningful while dma_grant=1)
//   hold       out  1 = CPU runs this cycle, 0 = CPU held
//   dma_grant  out  1 = DMA owns the bus
//   cfg_pend   out  1 = shadow config waiting to be applied
// ---------------------------------------------------------------------------
module cpu_scheduler (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_freq,
  input  logic [7:0] cfg_fref,
  input  logic       dma_req,
  input  logic       dma_last,
  output logic       hold,
  output logic       dma_grant,
  output logic       cfg_pend
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DMA   = 2'd2
  } state_t;

  state_t     state_reg;
  logic [8:0] acc_reg;
  logic [7:0] cur_freq_reg;
  logic [7:0] cur_fref_reg;
  logic [7:0] shadow_freq_reg;
  logic [7:0] shadow_fref_reg;
  logic       owed_reg;

  logic [7:0] fq;
  logic [8:0] acc_sum;
  logic       fref_zero;
  logic       tick;
  logic       stalled;
  logic       owed_eff;

  // acc is always below cur_fref, so acc + fq stays within 9 bits.
  always_comb begin
    fq        = (cur_freq_reg < cur_fref_reg) ? cur_freq_reg : cur_fref_reg;
    acc_sum   = acc_reg + {1'b0, fq};
    fref_zero = (cur_fref_reg == 8'd0);
    tick      = fref_zero || (acc_sum >= {1'b0, cur_fref_reg});
    // A zero rate never produces a running cycle. A debt owed to the CPU
    // could then never be repaid, so it is treated as already paid.
    stalled   = (fq == 8'd0) && !fref_zero;
    owed_eff  = owed_reg && !stalled;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= ST_RUN;
      acc_reg         <= 9'd0;
      cur_freq_reg    <= 8'd0;
      cur_fref_reg    <= 8'd0;
      shadow_freq_reg <= 8'd0;
      shadow_fref_reg <= 8'd0;
      owed_reg        <= 1'b0;
      hold            <= 1'b0;
      dma_grant       <= 1'b0;
      cfg_pend        <= 1'b0;
    end else begin
      // A shadow write wins over a same-edge apply. The apply below uses
      // the old shadow value, and pending stays set for the new one.
      if (cfg_we) begin
        shadow_freq_reg <= cfg_freq;
        shadow_fref_reg <= cfg_fref;
        cfg_pend        <= 1'b1;
      end

      case (state_reg)
        ST_RUN: begin
          if (dma_req && !owed_eff) begin
            // Freeze acc and hand over after the CPU drains its bus cycle.
            state_reg <= ST_DRAIN;
            hold      <= 1'b0;
          end else begin
            hold <= tick;
            if (tick || stalled) begin
              owed_reg <= 1'b0;
            end
            if (tick && cfg_pend) begin
              cur_freq_reg <= shadow_freq_reg;
              cur_fref_reg <= shadow_fref_reg;
              acc_reg      <= 9'd0;
              if (!cfg_we) begin
                cfg_pend <= 1'b0;
              end
            end else if (fref_zero) begin
              acc_reg <= 9'd0;
            end else if (tick) begin
              acc_reg <= acc_sum - {1'b0, cur_fref_reg};
            end else begin
              acc_reg <= acc_sum;
            end
          end
        end

        ST_DRAIN: begin
          hold <= 1'b0;
          if (dma_req) begin
            state_reg <= ST_DMA;
            dma_grant <= 1'b1;
          end else begin
            state_reg <= ST_RUN;
          end
        end

        ST_DMA: begin
          // dma_req is deliberately ignored here; only dma_last ends a burst.
          hold <= 1'b0;
          if (dma_last) begin
            state_reg <= ST_RUN;
            dma_grant <= 1'b0;
            owed_reg  <= !stalled;
          end
        end

        default: begin
          state_reg <= ST_RUN;
          hold      <= 1'b0;
          dma_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cpu_scheduler
//
// Directed bench for cpu_scheduler. All expected values are hand-derived.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so each sample shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_cpu_scheduler;

  logic       clock;
  logic       reset_n;
  logic       cfg_we;
  logic [7:0] cfg_freq;
  logic [7:0] cfg_fref;
  logic       dma_req;
  logic       dma_last;
  logic       hold;
  logic       dma_grant;
  logic       cfg_pend;

  int n_checks;
  int n_fail;

  cpu_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_freq  (cfg_freq),
    .cfg_fref  (cfg_fref),
    .dma_req   (dma_req),
    .dma_last  (dma_last),
    .hold      (hold),
    .dma_grant (dma_grant),
    .cfg_pend  (cfg_pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    dma_req  = 1'b0;
    dma_last = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Reset, write a config, and take the edge that applies it.
  // With cur_fref==0 every edge ticks, so the apply edge is the next edge.
  task automatic apply_cfg(input logic [7:0] f, input logic [7:0] r);
    do_reset();
    cfg_we   = 1'b1;
    cfg_freq = f;
    cfg_fref = r;
    step();
    cfg_we = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    cfg_we   = 1'b1;
    cfg_freq = 8'd7;
    cfg_fref = 8'd9;
    dma_req  = 1'b0;
    dma_last = 1'b0;
    step();
    n_checks++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: hold=%b expected 0", hold); end
    n_checks++;
    if (dma_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: dma_grant=%b expected 0", dma_grant); end
    n_checks++;
    if (cfg_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: cfg_pend=%b expected 0", cfg_pend); end
    reset_n = 1'b1;
    cfg_we  = 1'b0;
    step();
    n_checks++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL reset_release_hold: hold=%b expected 1", hold); end
    n_checks++;
    if (cfg_pend !== 1'b0) begin n_fail++; $display("FAIL reset_release_pend: cfg_pend=%b expected 0", cfg_pend); end
    $display("test_reset done");
  endtask

  task automatic test_rate_half();
    do_reset();
    cfg_we   = 1'b1;
    cfg_freq = 8'd125;
    cfg_fref = 8'd250;
    step();
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1) begin n_fail++; $display("FAIL half_pend_set: cfg_pend=%b expected 1", cfg_pend); end
    step();
    n_checks++;
    if (cfg_pend !== 1'b0) begin n_fail++; $display("FAIL half_pend_clear: cfg_pend=%b expected 0", cfg_pend); end
    n_checks++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL half_apply_hold: hold=%b expected 1", hold); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (hold !== ((i % 2) == 1)) begin
        n_fail++;
        $display("FAIL half_pattern[%0d]: hold=%b expected %b", i, hold, (i % 2) == 1);
      end
    end
    $display("test_rate_half done");
  endtask

  task automatic test_rate_third();
    apply_cfg(8'd1, 8'd3);
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++;
      if (hold !== ((i % 3) == 2)) begin
        n_fail++;
        $display("FAIL third_pattern[%0d]: hold=%b expected %b", i, hold, (i % 3) == 2);
      end
    end
    $display("test_rate_third done");
  endtask

  task automatic test_rate_clamp();
    apply_cfg(8'd200, 8'd100);
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (hold !== 1'b1) begin n_fail++; $display("FAIL clamp_pattern[%0d]: hold=%b expected 1", i, hold); end
    end
    $display("test_rate_clamp done");
  endtask

  task automatic test_dma_burst();
    // Expected after each edge Ea..Ek: hold, dma_grant.
    logic exp_hold  [0:10];
    logic exp_grant [0:10];
    exp_hold  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    exp_grant = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    apply_cfg(8'd125, 8'd250);
    step();  // acc becomes 125, so the burst freezes a non-zero phase
    n_checks++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL burst_pre_hold: hold=%b expected 0", hold); end
    for (int i = 0; i < 11; i++) begin
      // Request held for Ea..Eh. dma_last is sampled at Ef, during the 4th grant cycle.
      dma_req  = (i <= 7);
      dma_last = (i == 5);
      step();
      n_checks++;
      if (hold !== exp_hold[i]) begin
        n_fail++;
        $display("FAIL burst_hold[%0d]: hold=%b expected %b", i, hold, exp_hold[i]);
      end
      n_checks++;
      if (dma_grant !== exp_grant[i]) begin
        n_fail++;
        $display("FAIL burst_grant[%0d]: dma_grant=%b expected %b", i, dma_grant, exp_grant[i]);
      end
    end
    dma_req  = 1'b0;
    dma_last = 1'b0;
    $display("test_dma_burst done");
  endtask

  task automatic test_dma_pulse();
    do_reset();
    dma_req = 1'b1;
    step();
    dma_req = 1'b0;
    n_checks++;
    if (hold !== 1'b0 || dma_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_drain: hold=%b grant=%b expected 0 0", hold, dma_grant);
    end
    step();
    n_checks++;
    if (hold !== 1'b0 || dma_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_back_to_run: hold=%b grant=%b expected 0 0", hold, dma_grant);
    end
    step();
    n_checks++;
    if (hold !== 1'b1 || dma_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_resume: hold=%b grant=%b expected 1 0", hold, dma_grant);
    end
    $display("test_dma_pulse done");
  endtask

  task automatic test_reset_mid_dma();
    do_reset();
    dma_req = 1'b1;
    step();
    step();
    n_checks++;
    if (dma_grant !== 1'b1) begin n_fail++; $display("FAIL middma_grant: dma_grant=%b expected 1", dma_grant); end
    cfg_we   = 1'b1;
    cfg_freq = 8'd1;
    cfg_fref = 8'd3;
    step();
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_pend !== 1'b1 || dma_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL middma_pend: cfg_pend=%b grant=%b expected 1 1", cfg_pend, dma_grant);
    end
    reset_n = 1'b0;
    step();
    n_checks++;
    if (dma_grant !== 1'b0 || hold !== 1'b0 || cfg_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL middma_reset: grant=%b hold=%b pend=%b expected 0 0 0", dma_grant, hold, cfg_pend);
    end
    reset_n = 1'b1;
    dma_req = 1'b0;
    step();
    n_checks++;
    if (hold !== 1'b1 || dma_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL middma_release: hold=%b grant=%b expected 1 0", hold, dma_grant);
    end
    $display("test_reset_mid_dma done");
  endtask

  task automatic test_stalled_dma();
    apply_cfg(8'd0, 8'd10);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (hold !== 1'b0) begin n_fail++; $display("FAIL stalled_hold[%0d]: hold=%b expected 0", i, hold); end
    end
    dma_req = 1'b1;
    step();  // DRAIN
    step();  // DMA
    n_checks++;
    if (dma_grant !== 1'b1) begin n_fail++; $display("FAIL stalled_grant1: dma_grant=%b expected 1", dma_grant); end
    dma_last = 1'b1;
    step();  // back to RUN, nothing owed
    dma_last = 1'b0;
    n_checks++;
    if (dma_grant !== 1'b0) begin n_fail++; $display("FAIL stalled_release: dma_grant=%b expected 0", dma_grant); end
    step();  // straight into DRAIN
    n_checks++;
    if (hold !== 1'b0 || dma_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL stalled_redrain: hold=%b grant=%b expected 0 0", hold, dma_grant);
    end
    step();
    n_checks++;
    if (dma_grant !== 1'b1) begin n_fail++; $display("FAIL stalled_regrant: dma_grant=%b expected 1", dma_grant); end
    dma_req  = 1'b0;
    dma_last = 1'b1;
    step();
    dma_last = 1'b0;
    n_checks++;
    if (dma_grant !== 1'b0 || hold !== 1'b0) begin
      n_fail++;
      $display("FAIL stalled_end: grant=%b hold=%b expected 0 0", dma_grant, hold);
    end
    $display("test_stalled_dma done");
  endtask

  task automatic test_back_to_back_cfg();
    do_reset();
    cfg_we   = 1'b1;
    cfg_freq = 8'd1;
    cfg_fref = 8'd3;
    step();  // E0: shadow = 1/3
    cfg_freq = 8'd200;
    cfg_fref = 8'd100;
    step();  // E1: 1/3 applies, 200/100 stays pending
    n_checks++;
    if (cfg_pend !== 1'b1 || hold !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_coincide: pend=%b hold=%b expected 1 1", cfg_pend, hold);
    end
    cfg_freq = 8'd125;
    cfg_fref = 8'd250;
    step();  // E2: shadow overwritten with 125/250
    cfg_we = 1'b0;
    n_checks++;
    if (hold !== 1'b0 || cfg_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_e2: hold=%b pend=%b expected 0 1", hold, cfg_pend);
    end
    step();  // E3
    n_checks++;
    if (hold !== 1'b0 || cfg_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_e3: hold=%b pend=%b expected 0 1", hold, cfg_pend);
    end
    step();  // E4: tick applies 125/250
    n_checks++;
    if (hold !== 1'b1 || cfg_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_apply: hold=%b pend=%b expected 1 0", hold, cfg_pend);
    end
    step();  // E5
    n_checks++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL b2b_e5: hold=%b expected 0", hold); end
    step();  // E6
    n_checks++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL b2b_e6: hold=%b expected 1", hold); end
    $display("test_back_to_back_cfg done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    cfg_freq = 8'd0;
    cfg_fref = 8'd0;
    dma_req  = 1'b0;
    dma_last = 1'b0;
    #2;
    test_reset();
    test_rate_half();
    test_rate_third();
    test_rate_clamp();
    test_dma_burst();
    test_dma_pulse();
    test_reset_mid_dma();
    test_stalled_dma();
    test_back_to_back_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
